// File: rtl/spi_rx_word_packer_if.sv
// AXI4-Stream word channel from the SPI RX word packer to its consumer (DMA).
interface spi_rx_word_packer_if;
  logic [31:0] tdata;
  logic        tvalid;
  logic        tready;
  logic        tlast;

  modport master (
    output tdata,
    output tvalid,
    output tlast,
    input  tready
  );

  modport slave (
    input  tdata,
    input  tvalid,
    input  tlast,
    output tready
  );
endinterface

// File: rtl/spi_rx_word_packer.sv
// Packs SPI RX bytes into 32-bit words, buffers them in a FWFT FIFO and streams them out,
// flagging the last word of each trigger frame with tlast.
module spi_rx_word_packer #(
  parameter int unsigned BYTES_PER_WORD  = 4,
  parameter int unsigned WORDS_PER_FRAME = 16,
  parameter int unsigned FIFO_DEPTH      = 8,
  parameter bit          MSB_FIRST       = 1'b1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        i_RX_DV,
  input  logic [7:0]                  i_RX_Byte,
  input  logic                        i_frame_start,
  input  logic                        i_clear_overflow,
  spi_rx_word_packer_if.master        m_axis,
  output logic                        o_frame_done,
  output logic                        o_overflow
);

  localparam int unsigned AW  = $clog2(FIFO_DEPTH);
  localparam int unsigned BCW = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;
  localparam int unsigned WCW = (WORDS_PER_FRAME > 1) ? $clog2(WORDS_PER_FRAME) : 1;

  localparam logic [BCW-1:0] LastByte = BCW'(BYTES_PER_WORD - 1);
  localparam logic [WCW-1:0] LastWord = WCW'(WORDS_PER_FRAME - 1);
  localparam logic [AW:0]    DepthCnt = (AW + 1)'(FIFO_DEPTH);

  // Reset synchronizer: assertion is asynchronous, release is aligned to clk.
  logic [1:0] r_rst_sync;
  logic       w_rst_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rst_sync <= 2'b00;
    end else begin
      r_rst_sync <= {r_rst_sync[0], 1'b1};
    end
  end

  assign w_rst_n = r_rst_sync[1];

  // Byte assembly
  logic [BCW-1:0] r_byte_cnt;
  logic [WCW-1:0] r_word_cnt;
  logic [31:0]    r_shift;
  logic [31:0]    w_shift_base;
  logic [31:0]    w_shift_nxt;
  logic           w_word_done;
  logic           w_word_last;

  always_comb begin
    w_shift_base = i_frame_start ? 32'h0 : r_shift;
    if (MSB_FIRST) begin
      w_shift_nxt = {w_shift_base[23:0], i_RX_Byte};
    end else begin
      w_shift_nxt = {i_RX_Byte, w_shift_base[31:8]};
    end
    // A byte arriving with i_frame_start is byte 0 of the new frame, never a word end.
    w_word_done = i_RX_DV && !i_frame_start && (r_byte_cnt == LastByte);
    w_word_last = (r_word_cnt == LastWord);
  end

  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_byte_cnt <= '0;
      r_word_cnt <= '0;
      r_shift    <= 32'h0;
    end else if (i_frame_start) begin
      r_word_cnt <= '0;
      r_byte_cnt <= i_RX_DV ? BCW'(1) : '0;
      r_shift    <= i_RX_DV ? w_shift_nxt : 32'h0;
    end else if (i_RX_DV) begin
      r_shift    <= w_shift_nxt;
      r_byte_cnt <= (r_byte_cnt == LastByte) ? '0 : r_byte_cnt + BCW'(1);
      if (w_word_done) begin
        r_word_cnt <= w_word_last ? '0 : r_word_cnt + WCW'(1);
      end
    end
  end

  // Completed word staged for one cycle before the FIFO write
  logic        r_push;
  logic        r_push_last;
  logic [31:0] r_push_data;

  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_push      <= 1'b0;
      r_push_last <= 1'b0;
      r_push_data <= 32'h0;
    end else begin
      r_push <= w_word_done;
      if (w_word_done) begin
        r_push_last <= w_word_last;
        r_push_data <= w_shift_nxt;
      end
    end
  end

  // Word FIFO
  logic [31:0]   r_mem_data [FIFO_DEPTH];
  logic          r_mem_last [FIFO_DEPTH];
  logic [AW:0]   r_wr_ptr;
  logic [AW:0]   r_rd_ptr;
  logic [AW-1:0] w_wr_idx;
  logic [AW-1:0] w_rd_idx;
  logic          w_full;
  logic          w_empty;
  logic          w_wr_en;
  logic          w_rd_en;

  always_comb begin
    w_wr_idx = r_wr_ptr[AW-1:0];
    w_rd_idx = r_rd_ptr[AW-1:0];
    w_empty  = (r_wr_ptr == r_rd_ptr);
    w_full   = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (w_wr_idx == w_rd_idx);
    // Full is judged before any same-cycle pop, so a push into a full FIFO always drops.
    w_wr_en  = r_push && !w_full;
    w_rd_en  = !w_empty && m_axis.tready;
  end

  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_mem_data[i] <= 32'h0;
        r_mem_last[i] <= 1'b0;
      end
    end else if (w_wr_en) begin
      r_mem_data[w_wr_idx] <= r_push_data;
      r_mem_last[w_wr_idx] <= r_push_last;
    end
  end

  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_wr_en) begin
        r_wr_ptr <= r_wr_ptr + (AW + 1)'(1);
      end
      if (w_rd_en) begin
        r_rd_ptr <= r_rd_ptr + (AW + 1)'(1);
      end
    end
  end

  // Status: frame_done tracks the frame boundary even when the last word is dropped
  logic r_frame_done;
  logic r_overflow;

  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_frame_done <= 1'b0;
      r_overflow   <= 1'b0;
    end else begin
      r_frame_done <= r_push && r_push_last;
      if (r_push && w_full) begin
        r_overflow <= 1'b1;
      end else if (i_clear_overflow) begin
        r_overflow <= 1'b0;
      end
    end
  end

  assign m_axis.tvalid = !w_empty;
  assign m_axis.tdata  = r_mem_data[w_rd_idx];
  assign m_axis.tlast  = r_mem_last[w_rd_idx];
  assign o_frame_done  = r_frame_done;
  assign o_overflow    = r_overflow;

`ifndef SYNTHESIS
  a_stall_stable: assert property (@(posedge clk) disable iff (!w_rst_n)
    (m_axis.tvalid && !m_axis.tready) |=>
      (m_axis.tvalid && $stable(m_axis.tdata) && $stable(m_axis.tlast)));

  a_no_overrun: assert property (@(posedge clk) disable iff (!w_rst_n)
    ((r_wr_ptr - r_rd_ptr) <= DepthCnt));
`endif

endmodule

// File: tb/tb_spi_rx_word_packer.sv
// Directed bench for spi_rx_word_packer: expected beats are queued by the stimulus and
// checked by an independent stream monitor.
module tb_spi_rx_word_packer;
  localparam int unsigned Wpf   = 2;
  localparam int unsigned Depth = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx_dv = 1'b0;
  logic [7:0] rx_byte = 8'h00;
  logic       frame_start = 1'b0;
  logic       clear_ovf = 1'b0;
  logic       frame_done;
  logic       overflow;

  spi_rx_word_packer_if axis ();

  spi_rx_word_packer #(
    .BYTES_PER_WORD  (4),
    .WORDS_PER_FRAME (Wpf),
    .FIFO_DEPTH      (Depth),
    .MSB_FIRST       (1'b1)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .i_RX_DV          (rx_dv),
    .i_RX_Byte        (rx_byte),
    .i_frame_start    (frame_start),
    .i_clear_overflow (clear_ovf),
    .m_axis           (axis),
    .o_frame_done     (frame_done),
    .o_overflow       (overflow)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] d;
    logic        l;
  } beat_t;

  beat_t exp_q[$];
  beat_t mon_e;
  int    n_cmp = 0;
  int    n_err = 0;
  int    fd_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  // Stream monitor: every accepted beat is compared against the head of the queue
  always @(negedge clk) begin
    if (rst_n) begin
      if (frame_done === 1'b1) fd_cnt++;
      if (axis.tvalid === 1'b1 && axis.tready === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_beat: got %h/%b, want no beat", axis.tdata, axis.tlast);
        end else begin
          mon_e = exp_q.pop_front();
          chk("beat_data", axis.tdata, mon_e.d);
          chk("beat_last", 32'(axis.tlast), 32'(mon_e.l));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b, input logic fs);
    rx_dv       = 1'b1;
    rx_byte     = b;
    frame_start = fs;
    tick();
    rx_dv       = 1'b0;
    frame_start = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send(w[31-8*i -: 8], 1'b0);
  endtask

  task automatic expect_beat(input logic [31:0] d, input logic l);
    exp_q.push_back({d, l});
  endtask

  task automatic pulse_fs();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  task automatic wait_drain(input string name, input int max_cycles);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < max_cycles) begin
      tick();
      k++;
    end
    chk(name, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] w;
    logic [7:0]  b;
    axis.tready = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    chk("rst_tvalid", 32'(axis.tvalid), 32'd0);
    chk("rst_tlast", 32'(axis.tlast), 32'd0);
    chk("rst_tdata", axis.tdata, 32'h0);
    chk("rst_frame_done", 32'(frame_done), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    tick();
    rst_n = 1'b1;
    repeat (4) tick();

    // 1: single word, MSB first, latency
    axis.tready = 1'b1;
    expect_beat(32'h12345678, 1'b0);
    send(8'h12, 1'b0);
    send(8'h34, 1'b0);
    send(8'h56, 1'b0);
    send(8'h78, 1'b0);
    @(negedge clk);
    chk("t1_tvalid_early", 32'(axis.tvalid), 32'd0);
    @(negedge clk);
    chk("t1_tvalid_latency", 32'(axis.tvalid), 32'd1);
    wait_drain("t1_drain", 20);

    // 2: one full frame of two words, realigned first
    pulse_fs();
    fd_cnt = 0;
    expect_beat(32'h00010203, 1'b0);
    expect_beat(32'h04050607, 1'b1);
    for (int i = 0; i < 8; i++) send(8'(i), 1'b0);
    wait_drain("t2_drain", 20);
    repeat (3) tick();
    chk("t2_frame_done_cnt", 32'(fd_cnt), 32'd1);

    // 3: overflow with a stalled consumer; words 8 and 9 drop, 9 is a frame end
    axis.tready = 1'b0;
    fd_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      b = 8'(i);
      w = {8'h20 + b, 8'h30 + b, 8'h40 + b, 8'h50 + b};
      if (i < 8) expect_beat(w, b[0]);
      send_word(w);
    end
    repeat (2) tick();
    @(negedge clk);
    chk("t3_overflow", 32'(overflow), 32'd1);
    chk("t3_tvalid", 32'(axis.tvalid), 32'd1);
    chk("t3_head_hold", axis.tdata, 32'h20304050);
    chk("t3_frame_done_cnt", 32'(fd_cnt), 32'd5);
    clear_ovf = 1'b1;
    tick();
    clear_ovf = 1'b0;
    @(negedge clk);
    chk("t3_ovf_cleared", 32'(overflow), 32'd0);
    tick();
    // Drop coincides with clear: set must win
    send_word(32'h11111111);
    clear_ovf = 1'b1;
    tick();
    clear_ovf = 1'b0;
    @(negedge clk);
    chk("t3_set_beats_clear", 32'(overflow), 32'd1);
    tick();
    axis.tready = 1'b1;
    wait_drain("t3_drain", 40);
    @(negedge clk);
    chk("t3_empty_after", 32'(axis.tvalid), 32'd0);
    tick();

    // 4: partial word discarded by frame_start (word_cnt was 1)
    send(8'hEE, 1'b0);
    send(8'hFF, 1'b0);
    pulse_fs();
    expect_beat(32'hAABBCCDD, 1'b0);
    send_word(32'hAABBCCDD);
    wait_drain("t4_drain", 20);

    // 5: byte coincident with frame_start is byte 0 (word_cnt was 1)
    expect_beat(32'h5A112233, 1'b0);
    send(8'h5A, 1'b1);
    send(8'h11, 1'b0);
    send(8'h22, 1'b0);
    send(8'h33, 1'b0);
    wait_drain("t5_drain", 20);

    // 6: asynchronous reset with words queued
    axis.tready = 1'b0;
    send_word(32'h01010101);
    send_word(32'h02020202);
    send_word(32'h03030303);
    repeat (2) tick();
    @(negedge clk);
    chk("t6_tvalid_before", 32'(axis.tvalid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_async_tvalid", 32'(axis.tvalid), 32'd0);
    chk("t6_async_overflow", 32'(overflow), 32'd0);
    chk("t6_async_tdata", axis.tdata, 32'h0);
    tick();
    rst_n = 1'b1;
    repeat (4) tick();
    axis.tready = 1'b1;
    expect_beat(32'hCAFEBABE, 1'b0);
    expect_beat(32'h01020304, 1'b1);
    send_word(32'hCAFEBABE);
    send_word(32'h01020304);
    wait_drain("t6_drain", 20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
